twi_target: RTL and testbench
=============================

Name: twi_target

Overview:
- TWI (I2C) target/responder. It is the other end of the on-chip TWI master.
- Lets the MCU-side fabric act as a slave on a TWI bus, for board-test loopback and for inter-controller links.
- Oversamples SCL/SDA on the system clock and decodes START/STOP and address.
- Delivers written bytes on a valid strobe and fetches read bytes through a load handshake.
- Open-drain SDA only; no clock stretching.

Parameters:
- SLV_ADDR, 7'h50, 7-bit target address matched after START.
- FILT_LEN, 3, number of consecutive equal synchronized samples required before a filtered SCL/SDA level changes (range 1..7).

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  asynchronous active-high reset.
- twi_scl_i  in  1  bus SCL level (asynchronous).
- twi_sda_i  in  1  bus SDA level (asynchronous).
- twi_sda_oen  out  1  0 = drive SDA low, 1 = release (high-Z).
- rx_data  out  8  last byte written by the master.
- rx_vld  out  1  one-cycle pulse; rx_data is valid in the same cycle.
- tx_data  in  8  next byte to return on a read; sampled when tx_load = 1.
- tx_load  out  1  one-cycle pulse; tx_data is captured this cycle.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- busy  out  1  high from address match until STOP/START/NACK exit.
- rd_mode  out  1  R/W bit of the current matched transfer (1 = read).

Behaviour:
- Reset values:
  - twi_sda_oen = 1.
  - rx_data = 0; rx_vld, tx_load, start_det, stop_det, busy, rd_mode = 0.
  - FSM = IDLE; filtered SCL and SDA = 1.
- Input conditioning:
  - 2-FF synchronizer on each input, then a FILT_LEN stability filter.
  - Edge detectors act on the filtered levels. Sync-to-edge latency is 2 + FILT_LEN cycles.
- Bus events (filtered):
  - START: SDA falling while SCL = 1.
  - STOP: SDA rising while SCL = 1.
  - START and STOP are honoured in every state. They abort any transfer and release SDA in the same cycle.
  - START goes to ADDR, clears the bit counter, and pulses start_det.
  - STOP goes to IDLE and pulses stop_det.
- Bit timing:
  - Shift in SDA on the SCL rising edge.
  - Change twi_sda_oen only on an SCL falling edge; sync delay provides the hold time.
- FSM:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. On the 8th rising edge, compare bits[7:1] with SLV_ADDR.
    - Match: latch rd_mode = bit0, set busy, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP.
  - ADDR_ACK:
    - Drive SDA low from the 8th falling edge to the 9th falling edge.
    - Write: go to WR_DATA.
    - Read: pulse tx_load at the 8th falling edge, capture tx_data into the shift register, and drive its MSB at the 9th falling edge. Then go to RD_DATA.
  - WR_DATA:
    - Shift 8 bits. At the 8th rising edge, update rx_data and pulse rx_vld (1 cycle).
    - Go to WR_ACK: ACK low for the 9th clock, then return to WR_DATA.
    - Consecutive bytes are unlimited.
  - RD_DATA:
    - Present bits 7..0 on successive falling edges; a 1 bit = release.
    - After the 8th falling edge, release SDA and go to RD_ACK.
  - RD_ACK: sample master ACK on the 9th rising edge.
    - ACK (0): pulse tx_load at that rising edge and load the next byte. Its MSB is driven at the 9th falling edge; go to RD_DATA.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: SDA released, busy = 0. Exit only via START or STOP.
- Bit counter: 3 bits; wraps to 0 after each ACK slot.
- Simultaneous events:
  - A START/STOP detected in the same cycle as an SCL edge wins; the SCL edge is ignored.
  - rx_vld and tx_load never assert in the same cycle.
- RST_I asserted mid-transfer immediately releases SDA; no partial rx_vld is emitted.
- Both filtered inputs at reset = 1, so no spurious START after reset release.

Decomposition:
- Shared package (twi_define-style include) holds:
  - FSM state encodings: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - The default SLV_ADDR.
- One sub-module, twi_in_filter: synchronizer + FILT_LEN filter + rise/fall pulses. Instantiated twice (SCL, SDA).

Test Plan:
- Write to 0x50, bytes 0xA5, 0x3C, STOP:
  - ACK on bus after address and each byte.
  - rx_vld twice with rx_data 0xA5 then 0x3C.
  - start_det/stop_det each pulse once; busy falls at STOP.
- Address 0x51 written:
  - SDA never driven low; busy stays 0.
  - FSM sits in WAIT_STOP until STOP.
- Read from 0x50, tx_data = 0x96 then 0x0F, master ACKs byte 1 and NACKs byte 2:
  - Bus carries 0x96, 0x0F; tx_load pulses twice.
  - SDA released after the NACK.
- Write 0x50 byte 0x11, repeated START, read 0x50:
  - rx_vld once (0x11); start_det twice.
  - rd_mode goes 0 -> 1; the read returns tx_data.
- SDA/SCL glitch of FILT_LEN-1 cycles while idle and during data: no start_det/stop_det, no bit shift.
- RST_I pulsed during bit 4 of a read byte:
  - twi_sda_oen = 1 within the reset cycle; all outputs at reset values.
  - Next START plus address 0x50 is ACKed normally.

Source files
------------

// File: rtl/twi_target_pkg.sv
// rtl/twi_target_pkg.sv - shared TWI target state encodings and default address
package twi_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } twi_state_t;

    localparam logic [6:0] TWI_DEF_ADDR = 7'h50;

endpackage

// File: rtl/twi_target_if.sv
// rtl/twi_target_if.sv - TWI bus pins plus fabric-side byte handshake
interface twi_target_if;

    logic       twi_scl_i;
    logic       twi_sda_i;
    logic       twi_sda_oen;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       start_det;
    logic       stop_det;
    logic       busy;
    logic       rd_mode;

    modport slave (
        input  twi_scl_i, twi_sda_i, tx_data,
        output twi_sda_oen, rx_data, rx_vld, tx_load, start_det, stop_det, busy, rd_mode
    );

    modport master (
        output twi_scl_i, twi_sda_i, tx_data,
        input  twi_sda_oen, rx_data, rx_vld, tx_load, start_det, stop_det, busy, rd_mode
    );

endinterface

// File: rtl/twi_in_filter.sv
// rtl/twi_in_filter.sv - 2-FF synchronizer, FILT_LEN stability filter, edge pulses
module twi_in_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [2:0] CNT_MAX = 3'(FILT_LEN - 1);

    logic [1:0] sync;
    logic [2:0] cnt;
    logic       level_prev;

    // Level only moves after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= 2'b11;
            cnt        <= 3'd0;
            level      <= 1'b1;
            level_prev <= 1'b1;
        end else begin
            sync       <= {sync[0], din};
            level_prev <= level;
            if (sync[1] != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync[1];
                    cnt   <= 3'd0;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end else begin
                cnt <= 3'd0;
            end
        end
    end

    assign rise = level & ~level_prev;
    assign fall = ~level & level_prev;

endmodule

// File: rtl/twi_target.sv
// rtl/twi_target.sv - TWI target: address match, write bytes out, read bytes in
module twi_target
    import twi_target_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = TWI_DEF_ADDR,
    parameter int         FILT_LEN = 3
) (
    input  logic         CLK_I,
    input  logic         RST_I,
    twi_target_if.slave  bus
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    twi_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(CLK_I), .rst(RST_I), .din(bus.twi_scl_i),
        .level(scl), .rise(scl_rise), .fall(scl_fall)
    );

    twi_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(CLK_I), .rst(RST_I), .din(bus.twi_sda_i),
        .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    logic start_ev, stop_ev;
    assign start_ev = sda_fall & scl;
    assign stop_ev  = sda_rise & scl;

    twi_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d, rx_data_q, rx_data_d;
    logic       oen_q, oen_d, busy_q, busy_d, rd_q, rd_d;
    logic       rx_vld_q, rx_vld_d, tx_load_q, tx_load_d;
    logic       start_q, start_d, stop_q, stop_d;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            sh_q      <= 8'h00;
            rx_data_q <= 8'h00;
            oen_q     <= 1'b1;
            busy_q    <= 1'b0;
            rd_q      <= 1'b0;
            rx_vld_q  <= 1'b0;
            tx_load_q <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            rx_data_q <= rx_data_d;
            oen_q     <= oen_d;
            busy_q    <= busy_d;
            rd_q      <= rd_d;
            rx_vld_q  <= rx_vld_d;
            tx_load_q <= tx_load_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
        end
    end

    // In the ACK states cnt_q acts as a phase flag: 0 before the ACK slot opens, 1 inside it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        rx_data_d = rx_data_q;
        oen_d     = oen_q;
        busy_d    = busy_q;
        rd_d      = rd_q;
        rx_vld_d  = 1'b0;
        tx_load_d = 1'b0;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        if (start_ev) begin
            state_d = ST_ADDR;
            cnt_d   = 3'd0;
            oen_d   = 1'b1;
            busy_d  = 1'b0;
            start_d = 1'b1;
        end else if (stop_ev) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            oen_d   = 1'b1;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    sh_d  = {sh_q[6:0], sda};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (sh_q[6:0] == SLV_ADDR) begin
                            rd_d    = sda;
                            busy_d  = 1'b1;
                            state_d = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (cnt_q == 3'd0) begin
                        oen_d = 1'b0;
                        cnt_d = 3'd1;
                        if (state_q == ST_ADDR_ACK && rd_q) begin
                            tx_load_d = 1'b1;
                            sh_d      = bus.tx_data;
                        end
                    end else begin
                        cnt_d = 3'd0;
                        if (state_q == ST_ADDR_ACK && rd_q) begin
                            oen_d   = sh_q[7];
                            state_d = ST_RD_DATA;
                        end else begin
                            oen_d   = 1'b1;
                            state_d = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    sh_d  = {sh_q[6:0], sda};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d = {sh_q[6:0], sda};
                        rx_vld_d  = 1'b1;
                        state_d   = ST_WR_ACK;
                    end
                end
                ST_RD_DATA: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        oen_d   = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = ST_RD_ACK;
                    end else begin
                        oen_d = sh_q[6];
                        sh_d  = {sh_q[6:0], 1'b0};
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_RD_ACK: begin
                    if (cnt_q == 3'd0) begin
                        if (scl_rise) begin
                            if (!sda) begin
                                tx_load_d = 1'b1;
                                sh_d      = bus.tx_data;
                                cnt_d     = 3'd1;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end else if (scl_fall) begin
                        oen_d   = sh_q[7];
                        cnt_d   = 3'd0;
                        state_d = ST_RD_DATA;
                    end
                end
                ST_WAIT_STOP: begin
                    oen_d  = 1'b1;
                    busy_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.twi_sda_oen = oen_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_vld      = rx_vld_q;
    assign bus.tx_load     = tx_load_q;
    assign bus.start_det   = start_q;
    assign bus.stop_det    = stop_q;
    assign bus.busy        = busy_q;
    assign bus.rd_mode     = rd_q;

endmodule

// File: tb/tb_twi_target.sv
// tb/tb_twi_target.sv - directed bus-level bench for twi_target
module tb_twi_target;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_byte = 8'h00;

    always #5 clk = ~clk;

    twi_target_if tw ();
    assign tw.twi_scl_i = scl_m;
    assign tw.twi_sda_i = sda_m & tw.twi_sda_oen;
    assign tw.tx_data   = tx_byte;

    twi_target #(.SLV_ADDR(7'h50), .FILT_LEN(3)) dut (
        .CLK_I(clk),
        .RST_I(rst),
        .bus  (tw)
    );

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0, tx_cnt = 0, st_cnt = 0, sp_cnt = 0, low_cnt = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (tw.rx_vld) begin
                rx_cnt++;
                rx_q.push_back(tw.rx_data);
            end
            if (tw.tx_load)        tx_cnt++;
            if (tw.start_det)      st_cnt++;
            if (tw.stop_det)       sp_cnt++;
            if (!tw.twi_sda_oen)   low_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, input logic glitch, output logic got);
        tick(Q); sda_m = b;
        tick(Q); scl_m = 1'b1;
        tick(Q);
        if (glitch) begin
            sda_m = ~b; tick(2); sda_m = b;
        end
        got = tw.twi_sda_i;
        tick(Q); scl_m = 1'b0;
        if (glitch) begin
            tick(Q / 2); scl_m = 1'b1; tick(2); scl_m = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic ack);
        logic g;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], glitch, g);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic g;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, 1'b0, b[i]);
        bit_xfer(mack, 1'b0, g);
    endtask

    task automatic do_start();
        tick(Q); sda_m = 1'b1;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b0;
    endtask

    task automatic do_stop();
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b1;
        tick(2 * Q);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic       g;
        logic [7:0] rd;
        int rx0, tx0, st0, sp0, lo0;

        tick(4);
        chk("reset_outputs", {tw.twi_sda_oen, tw.rx_data, tw.rx_vld, tw.tx_load, tw.start_det,
                              tw.stop_det, tw.busy, tw.rd_mode}, {1'b1, 8'h00, 6'b000000});
        rst = 1'b0;
        tick(4 * Q);
        chk("no_start_after_reset", st_cnt, 0);

        // write 0x50: 0xA5, 0x3C
        rx0 = rx_cnt; st0 = st_cnt; sp0 = sp_cnt;
        do_start();
        write_byte(8'hA0, 1'b0, ack); chk("wr_addr_ack", ack, 1'b0);
        chk("wr_busy", tw.busy, 1'b1);
        chk("wr_rd_mode", tw.rd_mode, 1'b0);
        write_byte(8'hA5, 1'b0, ack); chk("wr_b0_ack", ack, 1'b0);
        write_byte(8'h3C, 1'b0, ack); chk("wr_b1_ack", ack, 1'b0);
        do_stop();
        chk("wr_rx_cnt", rx_cnt - rx0, 2);
        chk("wr_rx_d0", rx_q[rx0], 8'hA5);
        chk("wr_rx_d1", rx_q[rx0 + 1], 8'h3C);
        chk("wr_start_cnt", st_cnt - st0, 1);
        chk("wr_stop_cnt", sp_cnt - sp0, 1);
        chk("wr_busy_after_stop", tw.busy, 1'b0);

        // address 0x51 is ignored
        rx0 = rx_cnt; lo0 = low_cnt; sp0 = sp_cnt;
        do_start();
        write_byte(8'hA2, 1'b0, ack); chk("miss_addr_nack", ack, 1'b1);
        chk("miss_busy", tw.busy, 1'b0);
        write_byte(8'h00, 1'b0, ack); chk("miss_data_nack", ack, 1'b1);
        do_stop();
        chk("miss_never_low", low_cnt - lo0, 0);
        chk("miss_no_rx", rx_cnt - rx0, 0);
        chk("miss_stop_cnt", sp_cnt - sp0, 1);

        // read 0x50: 0x96 acked, 0x0F nacked
        tx0 = tx_cnt; rx0 = rx_cnt;
        tx_byte = 8'h96;
        do_start();
        write_byte(8'hA1, 1'b0, ack); chk("rd_addr_ack", ack, 1'b0);
        chk("rd_rd_mode", tw.rd_mode, 1'b1);
        chk("rd_busy", tw.busy, 1'b1);
        chk("rd_first_load", tx_cnt - tx0, 1);
        tx_byte = 8'h0F;
        read_byte(1'b0, rd); chk("rd_byte0", rd, 8'h96);
        read_byte(1'b1, rd); chk("rd_byte1", rd, 8'h0F);
        chk("rd_load_cnt", tx_cnt - tx0, 2);
        tick(Q);
        chk("rd_released_after_nack", tw.twi_sda_oen, 1'b1);
        chk("rd_busy_after_nack", tw.busy, 1'b0);
        do_stop();
        chk("rd_no_rx", rx_cnt - rx0, 0);

        // write 0x11, repeated START, read
        rx0 = rx_cnt; st0 = st_cnt;
        tx_byte = 8'h5A;
        do_start();
        write_byte(8'hA0, 1'b0, ack); chk("rs_waddr_ack", ack, 1'b0);
        write_byte(8'h11, 1'b0, ack); chk("rs_wdata_ack", ack, 1'b0);
        chk("rs_rd_mode_wr", tw.rd_mode, 1'b0);
        do_start();
        write_byte(8'hA1, 1'b0, ack); chk("rs_raddr_ack", ack, 1'b0);
        chk("rs_rd_mode_rd", tw.rd_mode, 1'b1);
        read_byte(1'b1, rd); chk("rs_rdata", rd, 8'h5A);
        do_stop();
        chk("rs_rx_cnt", rx_cnt - rx0, 1);
        chk("rs_rx_data", rx_q[rx0], 8'h11);
        chk("rs_start_cnt", st_cnt - st0, 2);

        // short glitches, idle then inside a write
        st0 = st_cnt; sp0 = sp_cnt;
        tick(Q); sda_m = 1'b0; tick(2); sda_m = 1'b1;
        tick(Q); scl_m = 1'b0; tick(2); scl_m = 1'b1;
        tick(2 * Q);
        chk("gl_idle_start", st_cnt - st0, 0);
        chk("gl_idle_stop", sp_cnt - sp0, 0);
        rx0 = rx_cnt; st0 = st_cnt; sp0 = sp_cnt;
        do_start();
        write_byte(8'hA0, 1'b0, ack); chk("gl_addr_ack", ack, 1'b0);
        write_byte(8'hC3, 1'b1, ack); chk("gl_data_ack", ack, 1'b0);
        do_stop();
        chk("gl_rx_cnt", rx_cnt - rx0, 1);
        chk("gl_rx_data", rx_q[rx0], 8'hC3);
        chk("gl_start_cnt", st_cnt - st0, 1);
        chk("gl_stop_cnt", sp_cnt - sp0, 1);

        // reset in the middle of a read byte
        rx0 = rx_cnt;
        tx_byte = 8'h00;
        do_start();
        write_byte(8'hA1, 1'b0, ack); chk("rst_addr_ack", ack, 1'b0);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, 1'b0, g);
        tick(Q);
        chk("rst_bit4_driven", tw.twi_sda_oen, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_outputs", {tw.twi_sda_oen, tw.rx_data, tw.rx_vld, tw.tx_load, tw.start_det,
                            tw.stop_det, tw.busy, tw.rd_mode}, {1'b1, 8'h00, 6'b000000});
        tick(3);
        rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        tick(4 * Q);
        chk("rst_no_rx", rx_cnt - rx0, 0);
        do_start();
        write_byte(8'hA0, 1'b0, ack); chk("rst_readdr_ack", ack, 1'b0);
        chk("rst_busy", tw.busy, 1'b1);
        do_stop();
        chk("rst_busy_end", tw.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
